pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised next-generation program-counter unit for the single-cycle MIPS datapath. It replaces the free-running PC register plus +4 adder. It selects the next fetch address from sequential, branch, jump, jump-register and exception sources, and supports stall and a flush pulse. It holds an exception PC (EPC) and sits between the control/decode logic and the instruction-memory address input.

Parameters:
WIDTH, 32, PC/address width in bits; legal range 28..64.
STEP, 4, sequential increment in bytes; must be a power of two and at least 4.
RESET_VECTOR, 0, PC value loaded on reset; must be STEP-aligned.
EXC_VECTOR, 32'h0000_0180, PC value loaded on exception or address error; zero-extended to WIDTH.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  hold PC; no redirect is taken while high, except exception.
branch_taken  input  1  conditional branch resolved taken this cycle.
branch_offset  input  16  signed word offset (instruction immediate).
jump  input  1  J/JAL-type jump this cycle.
jump_address  input  26  instruction target field.
jump_reg  input  1  JR/JALR this cycle.
reg_target  input  WIDTH  register-sourced jump target.
exception  input  1  synchronous exception request.
pc  output  WIDTH  current fetch address.
pc_plus_step  output  WIDTH  pc + STEP, combinational; also the link value.
epc  output  WIDTH  PC captured at the last exception/address error.
flush  output  1  registered one-cycle pulse after any non-sequential redirect.
addr_error  output  1  registered one-cycle pulse when a jump_reg target is misaligned.

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset. Everything updates on the rising edge of clk only.
- Reset values: pc=RESET_VECTOR, epc=0, flush=0, addr_error=0. Reset wins over every other input in the same cycle. Reset asserted mid-stall or mid-redirect discards the pending redirect.
- Arithmetic is modulo 2^WIDTH. Wrap from all-ones region to 0 is silent.
- pc_plus_step = pc + STEP.
- Branch target = pc_plus_step + (sign_extend(branch_offset) << 2), sign-extended to WIDTH.
- Jump target = {pc_plus_step[WIDTH-1:28], jump_address, 2'b00}.
- Misaligned means reg_target[log2(STEP)-1:0] != 0.
- Next-PC priority, highest first:
  1. reset
  2. exception: pc<=EXC_VECTOR, epc<=pc, flush<=1. This applies even when stall is high.
  3. stall: pc holds, flush<=0, addr_error<=0.
  4. jump_reg with a misaligned target: pc<=EXC_VECTOR, epc<=pc, addr_error<=1, flush<=1.
  5. jump_reg with an aligned target: pc<=reg_target, flush<=1.
  6. jump: pc<=jump target, flush<=1.
  7. branch_taken: pc<=branch target, flush<=1.
  8. Otherwise: pc<=pc_plus_step, flush<=0.
- Simultaneous control inputs resolve strictly by this priority. Lower-priority requests are dropped, not queued.
- A branch whose target equals pc_plus_step still counts as a redirect, so flush=1.
- flush and addr_error are asserted for exactly one cycle per event. They are never high while reset is high.
- Latency: a redirect requested in cycle N gives the new pc visible after edge N+1. flush is high during cycle N+1.
- epc changes only on an exception or address error.

Optional Feature:
Macro PC_PERF_EN.
- Defined: adds outputs redirect_count [31:0] and stall_count [31:0]. Both reset to 0 and saturate at 32'hFFFF_FFFF.
  - redirect_count increments on every cycle that sets flush<=1.
  - stall_count increments on every cycle with stall=1 and exception=0.
- Not defined: the ports and counter logic are absent. Core behaviour is identical.

Test Plan:
- Reset: hold reset 2 cycles, then release with no controls -> pc=0, then 4, 8, 12 on successive edges; flush=0.
- Branch: at pc=0x100 assert branch_taken, offset=16'hFFFE -> next pc=0xFC, flush=1 for one cycle. Offset 16'h0010 at pc=0x100 -> next pc=0x144.
- Jump-register: at pc=0x200 assert jump_reg with reg_target=0x1000 -> pc=0x1000. With reg_target=0x1002 -> pc=0x180, epc=0x200, addr_error=1 pulse.
- Priority/stall: stall+jump -> pc holds, no flush. stall+exception at pc=0x40 -> pc=0x180, epc=0x40. jump+branch_taken -> jump target wins.
- Wrap/jump region: pc=0xFFFF_FFFC sequential -> pc=0. At pc=0x3000_0000, jump with jump_address=26'h000_0010 -> pc=0x3000_0040.
- PC_PERF_EN: 3 redirects and 5 stall cycles -> redirect_count=3, stall_count=5. Reset mid-run -> both return to 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter unit for the single-cycle MIPS datapath. It replaces the
//   free-running PC register and its +STEP adder. Each cycle it picks the next
//   fetch address from one of these sources: sequential, branch, jump,
//   jump-register or exception. It also holds the exception PC (EPC) and
//   raises one-cycle flush / address-error pulses after redirects.
//
// Optional feature:
//   Define PC_PERF_EN to add the saturating redirect_count and stall_count
//   outputs. Without the macro those ports and their counters do not exist.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset (wins over everything)
//   stall          hold pc; only an exception may still redirect
//   branch_taken   conditional branch resolved taken this cycle
//   branch_offset  signed word offset (instruction immediate)
//   jump           J/JAL-type jump this cycle
//   jump_address   26-bit instruction target field
//   jump_reg       JR/JALR this cycle
//   reg_target     register-sourced jump target
//   exception      synchronous exception request
//   pc             current fetch address
//   pc_plus_step   pc + STEP (combinational; also the link value)
//   epc            pc captured at the last exception / address error
//   flush          registered one-cycle pulse after a non-sequential redirect
//   addr_error     registered one-cycle pulse on a misaligned jump_reg target
//   redirect_count (PC_PERF_EN) cycles that set flush, saturating
//   stall_count    (PC_PERF_EN) stalled cycles without exception, saturating
module pc_sequencer #(
  parameter int                WIDTH        = 32,
  parameter int                STEP         = 4,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [31:0]       EXC_VECTOR   = 32'h0000_0180
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [15:0]      branch_offset,
  input  logic             jump,
  input  logic [25:0]      jump_address,
  input  logic             jump_reg,
  input  logic [WIDTH-1:0] reg_target,
  input  logic             exception,
`ifdef PC_PERF_EN
  output logic [31:0]      redirect_count,
  output logic [31:0]      stall_count,
`endif
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic [WIDTH-1:0] epc,
  output logic             flush,
  output logic             addr_error
);

  localparam int               STEP_BITS = $clog2(STEP);
  localparam logic [WIDTH-1:0] EXC_ADDR  = WIDTH'(EXC_VECTOR);

  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] jump_target;
  logic             misaligned;

  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] epc_next;
  logic             flush_next;
  logic             addr_error_next;

  assign pc_plus_step = pc + WIDTH'(STEP);

  // The word offset is sign-extended before the <<2. That way a backward
  // branch wraps modulo 2^WIDTH.
  assign branch_target = pc_plus_step
                       + {{(WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};

  // The jump keeps the upper region bits of pc_plus_step. With a 28-bit PC
  // there are no region bits, so the target is just the shifted field.
  generate
    if (WIDTH > 28) begin : g_jump_region
      assign jump_target = {pc_plus_step[WIDTH-1:28], jump_address, 2'b00};
    end else begin : g_jump_flat
      assign jump_target = {jump_address, 2'b00};
    end
  endgenerate

  assign misaligned = (reg_target[STEP_BITS-1:0] != '0);

  // Next-PC selection by fixed priority. Lower-priority requests in the
  // same cycle are dropped. Reset is applied in the register block.
  always_comb begin
    pc_next         = pc_plus_step;
    epc_next        = epc;
    flush_next      = 1'b0;
    addr_error_next = 1'b0;
    if (exception) begin
      pc_next    = EXC_ADDR;
      epc_next   = pc;
      flush_next = 1'b1;
    end else if (stall) begin
      pc_next = pc;
    end else if (jump_reg && misaligned) begin
      pc_next         = EXC_ADDR;
      epc_next        = pc;
      flush_next      = 1'b1;
      addr_error_next = 1'b1;
    end else if (jump_reg) begin
      pc_next    = reg_target;
      flush_next = 1'b1;
    end else if (jump) begin
      pc_next    = jump_target;
      flush_next = 1'b1;
    end else if (branch_taken) begin
      // This branch is still a redirect even when its target equals pc_plus_step.
      pc_next    = branch_target;
      flush_next = 1'b1;
    end
  end

  // Architectural state. Reset discards any redirect that is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_VECTOR;
      epc        <= '0;
      flush      <= 1'b0;
      addr_error <= 1'b0;
    end else begin
      pc         <= pc_next;
      epc        <= epc_next;
      flush      <= flush_next;
      addr_error <= addr_error_next;
    end
  end

`ifdef PC_PERF_EN
  // Performance counters. They stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_count <= '0;
      stall_count    <= '0;
    end else begin
      if (flush_next && (redirect_count != '1))
        redirect_count <= redirect_count + 32'd1;
      if (stall && !exception && (stall_count != '1))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed, self-checking bench for pc_sequencer with the default
//   parameters (32-bit, STEP 4, reset vector 0, exception vector 0x180).
//   A behavioural model advances on every rising edge. One compare process
//   checks every DUT output against that model on each falling edge. The
//   directed sequence also checks hand-computed literal values, which pin
//   down the model itself.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_address;
  logic        jump_reg;
  logic [31:0] reg_target;
  logic        exception;
  logic [31:0] pc;
  logic [31:0] pc_plus_step;
  logic [31:0] epc;
  logic        flush;
  logic        addr_error;
`ifdef PC_PERF_EN
  logic [31:0] redirect_count;
  logic [31:0] stall_count;
`endif

  int checks   = 0;
  int failures = 0;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_address  (jump_address),
    .jump_reg      (jump_reg),
    .reg_target    (reg_target),
    .exception     (exception),
`ifdef PC_PERF_EN
    .redirect_count(redirect_count),
    .stall_count   (stall_count),
`endif
    .pc            (pc),
    .pc_plus_step  (pc_plus_step),
    .epc           (epc),
    .flush         (flush),
    .addr_error    (addr_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Behavioural model. The next state is derived straight from the redirect
  // rules using plain 32-bit arithmetic.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        flush;
    logic        aerr;
    logic [31:0] rc;
    logic [31:0] sc;
  } model_t;

  model_t m;
  bit     model_valid = 0;

  function automatic model_t model_next(model_t c);
    model_t n = c;
    logic [31:0] seq = c.pc + 32'd4;
    n.flush = 1'b0;
    n.aerr  = 1'b0;
    if (reset) begin
      n.pc = 32'd0; n.epc = 32'd0; n.rc = 32'd0; n.sc = 32'd0;
      return n;
    end
    if (exception) begin
      n.pc = 32'h180; n.epc = c.pc; n.flush = 1'b1;
    end else if (stall) begin
      n.pc = c.pc;
    end else if (jump_reg) begin
      if ((reg_target % 4) != 0) begin
        n.pc = 32'h180; n.epc = c.pc; n.aerr = 1'b1; n.flush = 1'b1;
      end else begin
        n.pc = reg_target; n.flush = 1'b1;
      end
    end else if (jump) begin
      n.pc = (seq & 32'hF000_0000) | (32'(jump_address) * 32'd4);
      n.flush = 1'b1;
    end else if (branch_taken) begin
      n.pc = seq + 32'($signed(branch_offset) * 4);
      n.flush = 1'b1;
    end else begin
      n.pc = seq;
    end
    if (n.flush && c.rc != 32'hFFFF_FFFF) n.rc = c.rc + 32'd1;
    if (stall && !exception && c.sc != 32'hFFFF_FFFF) n.sc = c.sc + 32'd1;
    return n;
  endfunction

  // The model steps on the same edge as the DUT. It becomes valid once it
  // has seen a reset.
  always @(posedge clk) begin
    if (reset) model_valid <= 1'b1;
    m <= model_next(m);
  end

  // Per-cycle comparison, taken away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("model_pc", {32'd0, pc}, {32'd0, m.pc});
      checkOutput("model_pc_plus_step", {32'd0, pc_plus_step}, {32'd0, m.pc + 32'd4});
      checkOutput("model_epc", {32'd0, epc}, {32'd0, m.epc});
      checkOutput("model_flush", {63'd0, flush}, {63'd0, m.flush});
      checkOutput("model_addr_error", {63'd0, addr_error}, {63'd0, m.aerr});
`ifdef PC_PERF_EN
      checkOutput("model_redirect_count", {32'd0, redirect_count}, {32'd0, m.rc});
      checkOutput("model_stall_count", {32'd0, stall_count}, {32'd0, m.sc});
`endif
    end
  end

  // Drives one cycle of inputs, then returns on the next falling edge, so
  // the outputs already reflect the rising edge in between.
  task automatic applyStimulus(input logic rst, input logic st, input logic ex,
                               input logic jr, input logic [31:0] rt,
                               input logic j, input logic [25:0] ja,
                               input logic br, input logic [15:0] off);
    reset         = rst;
    stall         = st;
    exception     = ex;
    jump_reg      = jr;
    reg_target    = rt;
    jump          = j;
    jump_address  = ja;
    branch_taken  = br;
    branch_offset = off;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 32'd0, 0, 26'd0, 0, 16'd0);
  endtask

  task automatic setPc(input logic [31:0] target);
    applyStimulus(0, 0, 0, 1, target, 0, 26'd0, 0, 16'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; exception = 1'b0; jump_reg = 1'b0;
    reg_target = '0; jump = 1'b0; jump_address = '0; branch_taken = 1'b0;
    branch_offset = '0;

    // Reset held for two cycles, then a sequential run.
    applyStimulus(1, 0, 0, 0, 32'd0, 0, 26'd0, 0, 16'd0);
    applyStimulus(1, 0, 0, 0, 32'd0, 0, 26'd0, 0, 16'd0);
    checkOutput("reset_pc", {32'd0, pc}, 64'h0);
    checkOutput("reset_epc", {32'd0, epc}, 64'h0);
    checkOutput("reset_flush", {63'd0, flush}, 64'h0);
    checkOutput("reset_addr_error", {63'd0, addr_error}, 64'h0);
    idle(); checkOutput("seq_pc_4", {32'd0, pc}, 64'h4);
    idle(); checkOutput("seq_pc_8", {32'd0, pc}, 64'h8);
    idle(); checkOutput("seq_pc_12", {32'd0, pc}, 64'hC);
    checkOutput("seq_flush", {63'd0, flush}, 64'h0);

    // Backward and forward branches from 0x100.
    setPc(32'h100);
    checkOutput("jr_pc_100", {32'd0, pc}, 64'h100);
    applyStimulus(0, 0, 0, 0, 32'd0, 0, 26'd0, 1, 16'hFFFE);
    checkOutput("branch_back_pc", {32'd0, pc}, 64'hFC);
    checkOutput("branch_back_flush", {63'd0, flush}, 64'h1);
    idle();
    checkOutput("flush_one_cycle", {63'd0, flush}, 64'h0);
    checkOutput("after_branch_pc", {32'd0, pc}, 64'h100);
    applyStimulus(0, 0, 0, 0, 32'd0, 0, 26'd0, 1, 16'h0010);
    checkOutput("branch_fwd_pc", {32'd0, pc}, 64'h144);

    // Aligned and misaligned jump-register.
    setPc(32'h200);
    setPc(32'h1000);
    checkOutput("jr_aligned_pc", {32'd0, pc}, 64'h1000);
    setPc(32'h200);
    setPc(32'h1002);
    checkOutput("jr_misaligned_pc", {32'd0, pc}, 64'h180);
    checkOutput("jr_misaligned_epc", {32'd0, epc}, 64'h200);
    checkOutput("jr_misaligned_addr_error", {63'd0, addr_error}, 64'h1);
    checkOutput("jr_misaligned_flush", {63'd0, flush}, 64'h1);
    idle();
    checkOutput("addr_error_one_cycle", {63'd0, addr_error}, 64'h0);
    checkOutput("epc_held", {32'd0, epc}, 64'h200);

    // Stall blocks a jump. An exception overrides the stall.
    applyStimulus(0, 1, 0, 0, 32'd0, 1, 26'h10, 0, 16'd0);
    checkOutput("stall_jump_pc", {32'd0, pc}, 64'h184);
    checkOutput("stall_jump_flush", {63'd0, flush}, 64'h0);
    setPc(32'h40);
    applyStimulus(0, 1, 1, 0, 32'd0, 0, 26'd0, 0, 16'd0);
    checkOutput("stall_exc_pc", {32'd0, pc}, 64'h180);
    checkOutput("stall_exc_epc", {32'd0, epc}, 64'h40);
    applyStimulus(0, 0, 0, 0, 32'd0, 1, 26'h10, 1, 16'h0100);
    checkOutput("jump_beats_branch_pc", {32'd0, pc}, 64'h40);

    // Address wrap and jump region bits.
    setPc(32'hFFFF_FFFC);
    idle();
    checkOutput("wrap_pc", {32'd0, pc}, 64'h0);
    setPc(32'h3000_0000);
    applyStimulus(0, 0, 0, 0, 32'd0, 1, 26'h000_0010, 0, 16'd0);
    checkOutput("jump_region_pc", {32'd0, pc}, 64'h3000_0040);

    // A zero-offset branch is still a redirect.
    applyStimulus(0, 0, 0, 0, 32'd0, 0, 26'd0, 1, 16'h0000);
    checkOutput("branch_zero_pc", {32'd0, pc}, 64'h3000_0044);
    checkOutput("branch_zero_flush", {63'd0, flush}, 64'h1);

    // Reset during stall + exception discards the redirect.
    applyStimulus(1, 1, 1, 0, 32'd0, 1, 26'h10, 0, 16'd0);
    checkOutput("reset_override_pc", {32'd0, pc}, 64'h0);
    checkOutput("reset_override_flush", {63'd0, flush}, 64'h0);
    checkOutput("reset_override_epc", {32'd0, epc}, 64'h0);

`ifdef PC_PERF_EN
    // Three redirects and five stalls, then a reset clears both counters.
    applyStimulus(1, 0, 0, 0, 32'd0, 0, 26'd0, 0, 16'd0);
    setPc(32'h100);
    setPc(32'h200);
    applyStimulus(0, 0, 0, 0, 32'd0, 0, 26'd0, 1, 16'h0004);
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 1, 0, 0, 32'd0, 0, 26'd0, 0, 16'd0);
    checkOutput("perf_redirects", {32'd0, redirect_count}, 64'd3);
    checkOutput("perf_stalls", {32'd0, stall_count}, 64'd5);
    applyStimulus(1, 0, 0, 0, 32'd0, 0, 26'd0, 0, 16'd0);
    checkOutput("perf_redirects_reset", {32'd0, redirect_count}, 64'd0);
    checkOutput("perf_stalls_reset", {32'd0, stall_count}, 64'd0);
`endif

    idle();
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
